// File: rtl/serial_logic_pkg.sv
// rtl/serial_logic_pkg.sv - shared types for the bit-serial logic sequencer
package serial_logic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } seq_state_t;

    typedef enum logic [1:0] {
        ROUTE_KEEP   = 2'd0,
        ROUTE_F_TO_A = 2'd1,
        ROUTE_F_TO_B = 2'd2,
        ROUTE_SWAP   = 2'd3
    } route_sel_t;

endpackage

// File: rtl/shift_reg_n.sv
// rtl/shift_reg_n.sv - N-bit right-shift register with parallel load (load wins)
module shift_reg_n #(
    parameter int N = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Load,
    input  logic         Shift_En,
    input  logic         Shift_In,
    input  logic [N-1:0] D,
    output logic [N-1:0] Q
);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Q <= '0;
        end else if (Load) begin
            Q <= D;
        end else if (Shift_En) begin
            Q <= {Shift_In, Q[N-1:1]};
        end
    end

endmodule

// File: rtl/serial_logic_sequencer.sv
// rtl/serial_logic_sequencer.sv - operand registers, routing mux and control FSM for a 1-bit compute unit
// Optional: SEQ_AUTO_REARM_EN makes HOLD a single cycle so a held Execute runs back-to-back.
module serial_logic_sequencer
    import serial_logic_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         LoadA,
    input  logic         LoadB,
    input  logic [N-1:0] Din,
    input  logic         Execute,
    input  logic [1:0]   R,
    input  logic         F_A_B,
    output logic         A_Bit_Out,
    output logic         B_Bit_Out,
    output logic [N-1:0] A,
    output logic [N-1:0] B,
    output logic         Busy,
    output logic         Done
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    seq_state_t     state;
    seq_state_t     state_nxt;
    logic [CW-1:0]  count;
    route_sel_t     rsel;
    logic           route_a;
    logic           route_b;
    logic           load_a_en;
    logic           load_b_en;
    logic           shift_en;

    assign A_Bit_Out = A[0];
    assign B_Bit_Out = B[0];
    assign rsel      = route_sel_t'(R);

    always_comb begin
        route_a = A[0];
        route_b = B[0];
        case (rsel)
            ROUTE_KEEP:   begin route_a = A[0];  route_b = B[0];  end
            ROUTE_F_TO_A: begin route_a = F_A_B; route_b = B[0];  end
            ROUTE_F_TO_B: begin route_a = A[0];  route_b = F_A_B; end
            ROUTE_SWAP:   begin route_a = B[0];  route_b = A[0];  end
            default:      begin route_a = A[0];  route_b = B[0];  end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // count restarts in IDLE so every run begins at zero
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count <= '0;
        end else if (state == SHIFT) begin
            count <= count + 1'b1;
        end else begin
            count <= '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!(LoadA || LoadB) && Execute) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (count == LAST) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
`ifdef SEQ_AUTO_REARM_EN
                state_nxt = IDLE;
`else
                if (!Execute) begin
                    state_nxt = IDLE;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        Busy      = (state == SHIFT);
        Done      = (state == HOLD);
        shift_en  = (state == SHIFT);
        load_a_en = (state == IDLE) && LoadA;
        load_b_en = (state == IDLE) && LoadB;
    end

    shift_reg_n #(.N(N)) u_reg_a (
        .Clk      (Clk),
        .Reset    (Reset),
        .Load     (load_a_en),
        .Shift_En (shift_en),
        .Shift_In (route_a),
        .D        (Din),
        .Q        (A)
    );

    shift_reg_n #(.N(N)) u_reg_b (
        .Clk      (Clk),
        .Reset    (Reset),
        .Load     (load_b_en),
        .Shift_En (shift_en),
        .Shift_In (route_b),
        .D        (Din),
        .Q        (B)
    );

endmodule

// File: tb/tb_serial_logic_sequencer.sv
// tb/tb_serial_logic_sequencer.sv - self-checking bench for serial_logic_sequencer
module tb_serial_logic_sequencer;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load_a = 1'b0;
    logic         load_b = 1'b0;
    logic [N-1:0] din = '0;
    logic         exec = 1'b0;
    logic [1:0]   r = 2'b00;
    logic         op_xor = 1'b0;
    logic         f_a_b;
    logic         a_bit;
    logic         b_bit;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;
    int busy_cnt = 0;

    // bench-side compute unit: AND or XOR of the presented bits
    assign f_a_b = op_xor ? (a_bit ^ b_bit) : (a_bit & b_bit);

    always #5 clk = ~clk;

    serial_logic_sequencer #(.N(N)) dut (
        .Clk       (clk),
        .Reset     (rst),
        .LoadA     (load_a),
        .LoadB     (load_b),
        .Din       (din),
        .Execute   (exec),
        .R         (r),
        .F_A_B     (f_a_b),
        .A_Bit_Out (a_bit),
        .B_Bit_Out (b_bit),
        .A         (a),
        .B         (b),
        .Busy      (busy),
        .Done      (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // operation-level model: phase 0 idle, 1 running (bits_left to go), 2 holding
    logic [N-1:0] ma, mb;
    int           mphase = 0;
    int           bits_left = 0;

    always @(posedge clk) begin
        logic f, ia, ib;
        if (rst) begin
            ma = '0; mb = '0; mphase = 0; bits_left = 0;
        end else if (mphase == 0) begin
            if (load_a || load_b) begin
                if (load_a) ma = din;
                if (load_b) mb = din;
            end else if (exec) begin
                mphase = 1;
                bits_left = N;
            end
        end else if (mphase == 1) begin
            f  = op_xor ? (ma[0] ^ mb[0]) : (ma[0] & mb[0]);
            ia = (r == 2'd1) ? f : (r == 2'd3) ? mb[0] : ma[0];
            ib = (r == 2'd2) ? f : (r == 2'd3) ? ma[0] : mb[0];
            ma = {ia, ma[N-1:1]};
            mb = {ib, mb[N-1:1]};
            bits_left--;
            if (bits_left == 0) mphase = 2;
        end else begin
`ifdef SEQ_AUTO_REARM_EN
            mphase = 0;
`else
            if (!exec) mphase = 0;
`endif
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("A", a, ma);
            chk("B", b, mb);
            chk("A_Bit_Out", a_bit, ma[0]);
            chk("B_Bit_Out", b_bit, mb[0]);
            chk("Busy", busy, mphase == 1);
            chk("Done", done, mphase == 2);
            if (busy) busy_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ab(input logic [N-1:0] da, input logic [N-1:0] db);
        load_a = 1'b1; din = da; tick();
        load_a = 1'b0; load_b = 1'b1; din = db; tick();
        load_b = 1'b0;
    endtask

    // one-cycle Execute pulse, then wait (bounded) for Done and check latency
    task automatic run_op(input logic xo, input logic [1:0] rs, input string tag);
        int lat;
        op_xor = xo; r = rs;
        busy_cnt = 0;
        exec = 1'b1; tick();
        exec = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (done) begin lat = i; break; end
        end
        chk({tag, "_done_latency"}, lat, N);
        chk({tag, "_busy_cycles"}, busy_cnt, N);
    endtask

    initial begin
        tick(); tick();
        cmp_en = 1'b1;
        chk("reset_A", a, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        rst = 1'b0;
        tick();

`ifndef SEQ_AUTO_REARM_EN
        load_ab(8'h33, 8'h55);
        run_op(1'b0, 2'b01, "and_fa");
        chk("and_fa_A", a, 8'h11);
        chk("and_fa_B", b, 8'h55);
        tick();

        load_ab(8'h33, 8'h55);
        run_op(1'b1, 2'b10, "xor_fb");
        chk("xor_fb_A", a, 8'h33);
        chk("xor_fb_B", b, 8'h66);
        tick();

        // Execute held through HOLD: no second run
        load_ab(8'h33, 8'h55);
        op_xor = 1'b0; r = 2'b01;
        exec = 1'b1;
        for (int i = 0; i < N + 6; i++) tick();
        busy_cnt = 0;
        for (int i = 0; i < 4; i++) tick();
        chk("held_no_rerun_busy", busy_cnt, 0);
        chk("held_done", done, 1);
        chk("held_A", a, 8'h11);
        exec = 1'b0; tick(); tick();

        load_ab(8'h33, 8'h55);
        run_op(1'b0, 2'b11, "swap");
        chk("swap_A", a, 8'h55);
        chk("swap_B", b, 8'h33);
        tick();

        load_ab(8'h33, 8'h55);
        run_op(1'b0, 2'b00, "keep");
        chk("keep_A", a, 8'h33);
        chk("keep_B", b, 8'h55);
        tick();

        // reset sampled on the 4th shift edge
        load_ab(8'h33, 8'h55);
        r = 2'b01;
        exec = 1'b1; tick();
        exec = 1'b0; tick(); tick(); tick();
        rst = 1'b1; tick();
        chk("midrst_A", a, 0);
        chk("midrst_B", b, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        rst = 1'b0; tick();

        // loads ignored during SHIFT and HOLD
        load_ab(8'h33, 8'h55);
        op_xor = 1'b0; r = 2'b01;
        exec = 1'b1; tick();
        load_a = 1'b1; din = 8'hFF;
        for (int i = 0; i < N + 3; i++) tick();
        chk("ign_load_done", done, 1);
        chk("ign_load_A", a, 8'h11);
        load_a = 1'b0; exec = 1'b0; tick(); tick();

        // coincident LoadA and Execute in IDLE: load first, shift one edge later
        load_a = 1'b1; din = 8'h33; exec = 1'b1; tick();
        chk("ld_exec_A", a, 8'h33);
        chk("ld_exec_busy", busy, 0);
        load_a = 1'b0; tick();
        chk("ld_exec_busy_next", busy, 1);
        exec = 1'b0;
        for (int i = 0; i < N + 2; i++) tick();
        chk("ld_exec_A_final", a, 8'h11);
`else
        begin
            int n_done;
            int d0, d1;
            n_done = 0; d0 = -1; d1 = -1;
            load_ab(8'h33, 8'h55);
            op_xor = 1'b0; r = 2'b01;
            exec = 1'b1;
            for (int i = 0; i < 25; i++) begin
                tick();
                if (done) begin
                    if (n_done == 0) d0 = i;
                    else if (n_done == 1) begin
                        d1 = i;
                        chk("rearm_run2_A", a, 8'h11);
                    end
                    n_done++;
                end
            end
            chk("rearm_done_count", n_done, 2);
            chk("rearm_done_first", d0, N);
            chk("rearm_done_second", d1, 2 * N + 2);
            exec = 1'b0;
            for (int i = 0; i < N + 4; i++) tick();
            chk("rearm_idle_busy", busy, 0);
        end
`endif

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
